inst_rom_loader: RTL and testbench

- Writer side of the instruction ROM port. Accepts a byte stream from the host/debug side and assembles it into 32-bit instruction words.
- Writes the words sequentially into InstROM through its write port (iRWrEn/iRWrDt/iRRdAd).
- After writing, reads the image back through the read port and verifies it against a running checksum.
- Holds the PC stage stalled until a verified image is present. This gives a run-time alternative to the simulation-time memory preload.

---
 rtl/inst_rom_loader.sv | 154 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: run-time writer for the instruction ROM.
//   Takes a little-endian byte stream from the host, packs it into 32-bit
//   words and writes them to consecutive ROM addresses. It then reads the
//   image back and compares a readback checksum with the write checksum.
//   The PC stage is held until a verified image is present.
// Ports:
//   clock, reset (async, active low)
//   io_inFromCtl_start/len        : load request (len = word count)
//   io_inFromHost_valid/data      : byte stream in
//   io_outToHost_ready            : byte stream ready
//   io_outToIR_*                  : ROM read/write port (address shared)
//   io_inFromIR_iRRdDt            : ROM read data, READ_LAT after iREn
//   io_outToPC_hold               : stall fetch
//   io_outToCtl_done/err/sum      : status levels and image checksum
module inst_rom_loader #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_inFromCtl_start,
  input  logic [ADDR_W:0]   io_inFromCtl_len,
  input  logic              io_inFromHost_valid,
  input  logic [7:0]        io_inFromHost_data,
  output logic              io_outToHost_ready,
  output logic              io_outToIR_iREn,
  output logic [ADDR_W-1:0] io_outToIR_iRRdAd,
  output logic              io_outToIR_iRWrEn,
  output logic [31:0]       io_outToIR_iRWrDt,
  input  logic [31:0]       io_inFromIR_iRRdDt,
  output logic              io_outToPC_hold,
  output logic              io_outToCtl_done,
  output logic              io_outToCtl_err,
  output logic [31:0]       io_outToCtl_sum
);
  localparam int CW = ADDR_W + 1;  // word counters: DEPTH itself is representable
  localparam int VW = ADDR_W + 2;  // verify counter also spans the drain cycles

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, ERROR} state_t;

  state_t          state, stateNxt;
  logic [CW-1:0]   lenQ, wordCnt;
  logic [1:0]      byteCnt;
  logic [23:0]     asmQ;
  logic [31:0]     wrDataQ, sumQ, rbSum, rbNext;
  logic            wrPend;
  logic [VW-1:0]   vCnt, lenExt;
  logic [READ_LAT:1] vldPipe;

  logic idleLike, lenBad, startAcc, accept, lastWr, rdIssue, rdLast;

  assign idleLike = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign lenBad   = (io_inFromCtl_len == '0) || (io_inFromCtl_len > CW'(DEPTH));
  assign startAcc = io_inFromCtl_start && idleLike && !lenBad;
  assign lenExt   = {1'b0, lenQ};

  // The write of the final word is the one cycle where the stream closes.
  assign lastWr  = wrPend && (wordCnt == lenQ - CW'(1));
  assign accept  = io_outToHost_ready && io_inFromHost_valid;
  assign rdIssue = (state == VERIFY) && (vCnt < lenExt);
  assign rdLast  = (state == VERIFY) && (vCnt == lenExt + VW'(READ_LAT) - VW'(1));
  assign rbNext  = rbSum + (vldPipe[READ_LAT] ? io_inFromIR_iRRdDt : 32'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt           = state;
    io_outToHost_ready = 1'b0;
    io_outToIR_iREn    = 1'b0;
    io_outToIR_iRWrEn  = 1'b0;
    io_outToIR_iRRdAd  = '0;
    io_outToPC_hold    = 1'b1;
    io_outToCtl_done   = 1'b0;
    io_outToCtl_err    = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        io_outToPC_hold  = (state != DONE);
        io_outToCtl_done = (state == DONE);
        io_outToCtl_err  = (state == ERROR);
        if (io_inFromCtl_start) stateNxt = lenBad ? ERROR : LOAD;
      end
      LOAD: begin
        io_outToHost_ready = !lastWr;
        io_outToIR_iRWrEn  = wrPend;
        if (wrPend) io_outToIR_iRRdAd = wordCnt[ADDR_W-1:0];
        if (lastWr) stateNxt = VERIFY;
      end
      VERIFY: begin
        io_outToIR_iREn = rdIssue;
        if (rdIssue) io_outToIR_iRRdAd = vCnt[ADDR_W-1:0];
        if (rdLast) stateNxt = (rbNext == sumQ) ? DONE : ERROR;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign io_outToIR_iRWrDt = wrDataQ;
  assign io_outToCtl_sum   = sumQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lenQ    <= '0;
      wordCnt <= '0;
      byteCnt <= '0;
      asmQ    <= '0;
      wrDataQ <= '0;
      wrPend  <= 1'b0;
      sumQ    <= '0;
      rbSum   <= '0;
      vCnt    <= '0;
      vldPipe <= '0;
    end else begin
      // Read-return tracker: bit READ_LAT marks the cycle data is valid.
      vldPipe[1] <= rdIssue;
      for (int i = 2; i <= READ_LAT; i++) vldPipe[i] <= vldPipe[i-1];

      wrPend <= 1'b0;
      if (startAcc) begin
        lenQ    <= io_inFromCtl_len;
        wordCnt <= '0;
        byteCnt <= '0;
        sumQ    <= '0;
        rbSum   <= '0;
        vCnt    <= '0;
      end
      if (accept) begin
        byteCnt <= byteCnt + 2'd1;
        case (byteCnt)
          2'd0: asmQ[7:0]   <= io_inFromHost_data;
          2'd1: asmQ[15:8]  <= io_inFromHost_data;
          2'd2: asmQ[23:16] <= io_inFromHost_data;
          default: begin
            // Word complete: issue the write next cycle while lane 0 of the
            // following word may already be arriving.
            wrDataQ <= {io_inFromHost_data, asmQ};
            wrPend  <= 1'b1;
          end
        endcase
      end
      if (wrPend) begin
        sumQ    <= sumQ + wrDataQ;
        wordCnt <= wordCnt + CW'(1);
      end
      if (state == VERIFY) begin
        vCnt  <= vCnt + VW'(1);
        rbSum <= rbNext;
      end
    end
  end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: directed sequence with random byte data and
// random stream gaps, ROM behavioural model, checksum/word reference model.
module tb_inst_rom_loader;
  localparam int ADDR_W = 8, DEPTH = 256, READ_LAT = 1;

  logic clock = 1'b0, reset = 1'b0, start = 1'b0, hValid = 1'b0;
  logic [ADDR_W:0] lenIn = '0;
  logic [7:0] hData = '0;
  logic hReady, iREn, iRWrEn, hold, done, err;
  logic [ADDR_W-1:0] iRRdAd;
  logic [31:0] iRWrDt, sum;
  logic [31:0] iRRdDt = '0;

  always #5 clock = ~clock;

  inst_rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset),
    .io_inFromCtl_start(start), .io_inFromCtl_len(lenIn),
    .io_inFromHost_valid(hValid), .io_inFromHost_data(hData),
    .io_outToHost_ready(hReady),
    .io_outToIR_iREn(iREn), .io_outToIR_iRRdAd(iRRdAd),
    .io_outToIR_iRWrEn(iRWrEn), .io_outToIR_iRWrDt(iRWrDt),
    .io_inFromIR_iRRdDt(iRRdDt),
    .io_outToPC_hold(hold), .io_outToCtl_done(done),
    .io_outToCtl_err(err), .io_outToCtl_sum(sum)
  );

  // ROM model with optional readback corruption.
  logic [31:0] rom [DEPTH];
  logic corrupt = 1'b0;
  logic [ADDR_W-1:0] corruptAddr = '0;
  logic [31:0] corruptVal = '0;
  always @(posedge clock) begin
    if (iRWrEn) rom[iRRdAd] <= iRWrDt;
    if (iREn) iRRdDt <= (corrupt && iRRdAd == corruptAddr) ? corruptVal : rom[iRRdAd];
  end

  // Passive monitor: records accepted bytes, writes and reads.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int nAcc = 0, accTot = 0, rdTot = 0, rdIdx = 0, rdAddrBad = 0, bothCnt = 0, doneErrCnt = 0;
  int fourthQ[$], wrCycQ[$], wrAQ[$];
  logic [31:0] wrDQ[$];
  always @(negedge clock) begin
    if (!reset || start) nAcc = 0;
    else if (hValid && hReady) begin
      if (nAcc % 4 == 3) fourthQ.push_back(cyc);
      nAcc++;
      accTot++;
    end
    if (iRWrEn) begin
      wrCycQ.push_back(cyc);
      wrAQ.push_back(int'(iRRdAd));
      wrDQ.push_back(iRWrDt);
    end
    if (iREn) begin
      if (int'(iRRdAd) != rdIdx) rdAddrBad++;
      rdIdx++;
      rdTot++;
    end else rdIdx = 0;
    if (iREn && iRWrEn) bothCnt++;
    if (done && err) doneErrCnt++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes packed little-endian, wrapping 32-bit sum.
  logic [7:0] bytesBuf [1024];
  function automatic logic [31:0] wordOf(input int i);
    return {bytesBuf[4*i+3], bytesBuf[4*i+2], bytesBuf[4*i+1], bytesBuf[4*i]};
  endfunction
  function automatic logic [31:0] sumOf(input int len);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < len; i++) s = s + wordOf(i);
    return s;
  endfunction
  task automatic randBytes(input int n);
    for (int i = 0; i < n; i++) bytesBuf[i] = 8'($urandom_range(255));
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_ready"}, hReady, 0);
    chk({tag, "_iREn"}, iREn, 0);
    chk({tag, "_iRWrEn"}, iRWrEn, 0);
    chk({tag, "_addr"}, iRRdAd, 0);
    chk({tag, "_wrdt"}, iRWrDt, 0);
    chk({tag, "_hold"}, hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sum"}, sum, 0);
  endtask

  task automatic pulseStart(input int len);
    @(posedge clock); #1;
    start = 1'b1; lenIn = (ADDR_W+1)'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic sendBytes(input int n, input int gapPct);
    bit acc;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        hValid = 1'b0; @(posedge clock); #1;
      end
      hValid = 1'b1; hData = bytesBuf[i]; acc = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clock);
        if (hReady) begin acc = 1'b1; @(posedge clock); #1; break; end
        @(posedge clock); #1;
      end
      if (!acc) begin
        chk("byte_accept", hReady, 1);
        hValid = 1'b0;
        return;
      end
    end
    hValid = 1'b0;
  endtask

  task automatic waitEnd(output int endCyc);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      if (done || err) break;
    end
    endCyc = cyc;
    chk("end_reached", done | err, 1);
  endtask

  task automatic runLoad(input string tag, input int len, input int gapPct, input bit expOk,
                         input bit startInVerify, input bit chkRestart, input bit extraBytes);
    int wrBase, fBase, rdBase, accBase, endCyc, nWr, badA, badD, badT;
    wrBase = wrAQ.size(); fBase = fourthQ.size(); rdBase = rdTot; accBase = accTot;
    pulseStart(len);
    if (chkRestart) begin
      @(negedge clock);
      chk({tag, "_restart_hold"}, hold, 1);
      chk({tag, "_restart_done"}, done, 0);
      @(posedge clock); #1;
    end
    sendBytes(len*4, gapPct);
    if (extraBytes) begin hValid = 1'b1; hData = 8'hAA; end
    if (startInVerify) begin
      for (int k = 0; k < 100; k++) begin
        @(negedge clock);
        if (iREn) break;
      end
      chk({tag, "_verify_seen"}, iREn, 1);
      @(posedge clock); #1; start = 1'b1; lenIn = '0;
      @(posedge clock); #1; start = 1'b0;
    end
    waitEnd(endCyc);
    hValid = 1'b0;
    nWr = wrAQ.size() - wrBase;
    chk({tag, "_wrcnt"}, nWr, len);
    badA = 0; badD = 0; badT = 0;
    if (nWr == len && fourthQ.size() - fBase >= len) begin
      for (int i = 0; i < len; i++) begin
        if (wrAQ[wrBase+i] != i) badA++;
        if (wrDQ[wrBase+i] !== wordOf(i)) badD++;
        if (wrCycQ[wrBase+i] != fourthQ[fBase+i] + 1) badT++;
      end
      chk({tag, "_verify_cycles"}, endCyc - wrCycQ[wrBase+len-1], len + READ_LAT + 1);
    end else badT = len;
    chk({tag, "_wr_addr_bad"}, badA, 0);
    chk({tag, "_wr_data_bad"}, badD, 0);
    chk({tag, "_wr_timing_bad"}, badT, 0);
    chk({tag, "_bytes_acc"}, accTot - accBase, len*4);
    chk({tag, "_rdcnt"}, rdTot - rdBase, len);
    chk({tag, "_sum"}, sum, sumOf(len));
    chk({tag, "_done"}, done, expOk);
    chk({tag, "_err"}, err, !expOk);
    chk({tag, "_hold"}, hold, !expOk);
  endtask

  initial begin
    int wr0, rd0;
    logic [31:0] lastSum;
    #2;
    chkReset("rst");
    @(posedge clock); #1; reset = 1'b1;

    // Two-word known image.
    bytesBuf[0] = 8'h13; bytesBuf[1] = 8'h00; bytesBuf[2] = 8'h00; bytesBuf[3] = 8'h00;
    bytesBuf[4] = 8'h93; bytesBuf[5] = 8'h00; bytesBuf[6] = 8'h10; bytesBuf[7] = 8'h00;
    runLoad("t1", 2, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_sum_const", sum, 32'h001000A6);
    chk("t1_rom0", rom[0], 32'h00000013);
    chk("t1_rom1", rom[1], 32'h00100093);

    // Readback corruption of word 1.
    corrupt = 1'b1; corruptAddr = 8'd1; corruptVal = 32'h00100094;
    runLoad("t2", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    corrupt = 1'b0;
    lastSum = sumOf(2);

    // Zero length: straight to ERROR without touching the ROM.
    wr0 = wrAQ.size(); rd0 = rdTot;
    pulseStart(0);
    @(negedge clock);
    chk("t3_err", err, 1);
    chk("t3_done", done, 0);
    chk("t3_hold", hold, 1);
    repeat (3) @(negedge clock);
    chk("t3_nowr", wrAQ.size() - wr0, 0);
    chk("t3_nord", rdTot - rd0, 0);
    chk("t3_sum_held", sum, lastSum);

    // Over-length, then a full-depth load with random gaps.
    wr0 = wrAQ.size(); rd0 = rdTot;
    pulseStart(DEPTH + 1);
    @(negedge clock);
    chk("t4_err", err, 1);
    chk("t4_nowr", wrAQ.size() - wr0, 0);
    chk("t4_nord", rdTot - rd0, 0);
    randBytes(DEPTH*4);
    runLoad("t4full", DEPTH, 30, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_last_addr", wrAQ[wrAQ.size()-1], DEPTH - 1);

    // Reset in the middle of a load.
    randBytes(16);
    pulseStart(4);
    sendBytes(5, 0);
    reset = 1'b0;
    #1;
    chkReset("t5_midrst");
    @(posedge clock); #1; reset = 1'b1;
    bytesBuf[0] = 8'hEF; bytesBuf[1] = 8'hBE; bytesBuf[2] = 8'hAD; bytesBuf[3] = 8'hDE;
    runLoad("t5", 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_rom0", rom[0], 32'hDEADBEEF);

    // Start during VERIFY is ignored.
    randBytes(32);
    runLoad("t6", 8, 20, 1'b1, 1'b1, 1'b0, 1'b0);

    // Start from DONE re-arms hold immediately.
    randBytes(4);
    runLoad("t7", 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random lengths and gaps.
    for (int r = 0; r < 3; r++) begin
      int len;
      len = int'($urandom_range(1, 24));
      randBytes(len*4);
      runLoad("trand", len, 25, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    chk("rd_addr_seq_bad", rdAddrBad, 0);
    chk("rd_wr_overlap", bothCnt, 0);
    chk("done_err_overlap", doneErrCnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
